interpolation_ram_reader: RTL

INTERPOLATION_RAM_READER -- requirements
Module: interpolation_ram_reader

---
 rtl/interpolation_ram_reader.sv | 133 +++++++++++++
 1 files changed

// File: rtl/interpolation_ram_reader.sv
// Burst reader: walks a RAM address range (wrapping at 2^ADDR_WIDTH) and streams the
// returned words out through a small skid FIFO with valid/ready back-pressure.
module interpolation_ram_reader #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [1:0]            dbg_state
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [LEN_W-1:0]      LEN_ONE   = 1;
  localparam logic [PTR_W-1:0]      PTR_ONE   = 1;
  localparam logic [CNT_W:0]        DEPTH_LIM = FIFO_DEPTH;

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2} state_t;

  // Stream handshake: a beat transfers on a rising edge where m_valid && m_ready;
  // while m_valid is high and m_ready low, m_data/m_valid/m_last hold.
  state_t                  state_q;
  logic                    busy_q, done_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_W-1:0]        len_q, issued_q, popped_q;
  logic [RD_LATENCY-1:0]   pipe_q;
  logic [CNT_W-1:0]        inflight_q, count_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];

  logic           accept, issue, ret, pop;
  logic [CNT_W:0] occupancy;

  // done_q blocks a restart in the completion cycle, so a start coinciding with done is dropped.
  assign accept    = start && (state_q == IDLE) && !done_q && (length != '0);
  assign occupancy = {1'b0, count_q} + {1'b0, inflight_q};
  assign issue     = (state_q == READ) && (issued_q < len_q) && (occupancy < DEPTH_LIM);
  assign ret       = pipe_q[RD_LATENCY-1];
  assign pop       = m_valid && m_ready;

  assign busy        = busy_q;
  assign done        = done_q;
  assign ram_rd_addr = addr_q;
  assign m_valid     = (count_q != '0);
  assign m_data      = mem_q[rd_ptr_q];
  assign m_last      = m_valid && (popped_q == len_q - LEN_ONE);
  assign dbg_state   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= READ;
            busy_q   <= 1'b1;
            len_q    <= length;
            issued_q <= '0;
            popped_q <= '0;
            addr_q   <= base_addr;
          end
        end
        READ: begin
          if (issue && (issued_q == len_q - LEN_ONE)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (pop && m_last) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (issue) begin
        addr_q   <= addr_q + ADDR_ONE;
        issued_q <= issued_q + LEN_ONE;
      end
      if (pop) popped_q <= popped_q + LEN_ONE;
    end
  end

  // Read-return tracker: one valid bit per outstanding read, aligned to RD_LATENCY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q     <= '0;
      inflight_q <= '0;
    end else begin
      pipe_q[0] <= issue;
      for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(ret);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (ret) begin
        mem_q[wr_ptr_q] <= ram_rd_data;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      count_q <= count_q + CNT_W'(ret) - CNT_W'(pop);
    end
  end

endmodule
